// File: rtl/wu_fetch.sv
// wu_fetch: instruction fetch sequencer issuing reads up to a bounded number in flight ahead of decode.
`ifndef MGR_INSTRUCTION_MEMORY_DEPTH
`define MGR_INSTRUCTION_MEMORY_DEPTH 64
`endif
`ifndef MGR_WU_ADDRESS_RANGE
`define MGR_WU_ADDRESS_RANGE [5:0]
`endif

module wu_fetch #(
  parameter int WUF_MAX_OUTSTANDING = 4,
  parameter int WUF_MEM_DEPTH = `MGR_INSTRUCTION_MEMORY_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset_poweron,
  input  logic                          sys__wuf__start,
  input  logic `MGR_WU_ADDRESS_RANGE    sys__wuf__start_addr,
  input  logic                          wud__wuf__halt,
  input  logic                          wum__wuf__stall,
  input  logic                          wum__wud__valid,
  input  logic                          wud__wum__ready,
  output logic `MGR_WU_ADDRESS_RANGE    wuf__wum__addr,
  output logic                          wuf__wum__read,
  output logic                          wuf__sys__busy
);
  localparam int OW = $clog2(WUF_MAX_OUTSTANDING + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t r_state, w_state_nx;
  logic `MGR_WU_ADDRESS_RANGE r_pc;
  localparam int AW = $bits(r_pc);
  logic [OW-1:0] r_out, w_out_nx;
  logic w_issue, w_dec;
  // The counter is bumped at issue so the read strobe already in the pipe is accounted for.
  assign w_issue = (r_state == RUN) & ~wum__wuf__stall & (r_out < OW'(WUF_MAX_OUTSTANDING)) & ~wud__wuf__halt;
  assign w_dec = wum__wud__valid & wud__wum__ready & (r_out != '0);
  assign w_out_nx = r_out + OW'(w_issue) - OW'(w_dec);
  assign wuf__sys__busy = r_state != IDLE;
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    w_state_nx = sys__wuf__start ? RUN : IDLE;
      RUN:     w_state_nx = wud__wuf__halt ? DRAIN : RUN;
      DRAIN:   w_state_nx = (w_out_nx == '0) ? IDLE : DRAIN;
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      r_state        <= IDLE;
      r_pc           <= '0;
      r_out          <= '0;
      wuf__wum__read <= 1'b0;
      wuf__wum__addr <= '0;
    end else begin
      r_state        <= w_state_nx;
      r_out          <= w_out_nx;
      wuf__wum__read <= w_issue;
      if (w_issue) begin
        wuf__wum__addr <= r_pc;
        r_pc           <= (r_pc == AW'(WUF_MEM_DEPTH - 1)) ? '0 : r_pc + AW'(1);
      end
      if (r_state == IDLE && sys__wuf__start) r_pc <= sys__wuf__start_addr;
    end
  end
endmodule
